// File: rtl/sink_byte_packer_pkg.sv
// Shared configuration for the dispatch output path.
//   sink_config   : word width produced by network_sink.
//   packer_config : byte packer defaults, frame FSM state type and a
//                   helper for sizing the fill counter.
package sink_config;
    localparam int SNK_WIDTH = 4;
endpackage

package packer_config;
    import sink_config::*;

    localparam int PKR_BYTE_W = 8;
    // Accumulator must hold one not-yet-full byte plus one incoming word.
    localparam int PKR_ACC_W  = PKR_BYTE_W + SNK_WIDTH - 1;
    localparam int PKR_FILL_W = $clog2(PKR_ACC_W + 1);

    typedef enum logic {EXP_COUNT, EXP_INDEX} pkr_state_t;

    // Fill counter width for an arbitrary accumulator width (counts 0..acc_w).
    function automatic int pkr_fill_w(input int acc_w);
        return $clog2(acc_w + 1);
    endfunction
endpackage

// File: rtl/sink_byte_packer.sv
// sink_byte_packer: packs the network_sink word stream (count word N then N
// index words) MSB-first into bytes for the host transmitter. The final byte
// of every frame is zero-padded and flagged with out_last, so each frame
// starts on a byte boundary.
// Ports:
//   clk, arstn          clock, asynchronous active-low reset
//   clr                 synchronous clear, overrides both handshakes
//   snk_valid/ready/snk input word stream
//   out_valid/ready     output byte handshake
//   out_data, out_last  packed byte (first stream bit in MSB), end of frame
module sink_byte_packer
    import packer_config::*;
#(
    parameter int WORD_WIDTH = sink_config::SNK_WIDTH,
    parameter int BYTE_WIDTH = PKR_BYTE_W
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  clr,
    input  logic                  snk_valid,
    output logic                  snk_ready,
    input  logic [WORD_WIDTH-1:0] snk,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BYTE_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam int ACC_W  = BYTE_WIDTH + WORD_WIDTH - 1;
    localparam int FILL_W = pkr_fill_w(ACC_W);
    localparam logic [FILL_W-1:0] BW_F = FILL_W'(BYTE_WIDTH);
    localparam logic [FILL_W-1:0] WW_F = FILL_W'(WORD_WIDTH);

    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [FILL_W-1:0]     fill_q, fill_d;
    logic [WORD_WIDTH-1:0] rem_q, rem_d;
    logic                  flush_q, flush_d;
    pkr_state_t            state_q, state_d;
    logic                  in_fire, out_fire;

    // Input is taken only while less than a full byte is buffered and no
    // frame tail is pending, so input and output handshakes are exclusive.
    assign snk_ready = (fill_q < BW_F) && !flush_q;
    assign out_valid = (fill_q >= BW_F) || (flush_q && (fill_q != '0));
    assign out_last  = out_valid && flush_q && (fill_q <= BW_F);
    assign out_data  = acc_q[ACC_W-1 -: BYTE_WIDTH];

    assign in_fire  = snk_valid && snk_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        acc_d   = acc_q;
        fill_d  = fill_q;
        rem_d   = rem_q;
        flush_d = flush_q;
        state_d = state_q;
        if (clr) begin
            acc_d   = '0;
            fill_d  = '0;
            rem_d   = '0;
            flush_d = 1'b0;
            state_d = EXP_COUNT;
        end else if (in_fire) begin
            // Bits below fill are always zero, so OR-ing the aligned word in
            // places it directly after the buffered bits.
            acc_d  = acc_q | ((ACC_W'(snk) << (ACC_W - WORD_WIDTH)) >> fill_q);
            fill_d = fill_q + WW_F;
            if (state_q == EXP_COUNT) begin
                if (snk == '0) begin
                    flush_d = 1'b1;
                end else begin
                    rem_d   = snk;
                    state_d = EXP_INDEX;
                end
            end else begin
                if (rem_q == WORD_WIDTH'(1)) begin
                    flush_d = 1'b1;
                    state_d = EXP_COUNT;
                end else begin
                    rem_d = rem_q - WORD_WIDTH'(1);
                end
            end
        end else if (out_fire) begin
            // A padded partial byte leaves fill at zero; shifting in zeros
            // keeps the unused low bits clear for the next frame.
            acc_d  = acc_q << BYTE_WIDTH;
            fill_d = (fill_q >= BW_F) ? (fill_q - BW_F) : '0;
            if (fill_d == '0) flush_d = 1'b0;
        end else if (flush_q && (fill_q == '0)) begin
            // Frame ended exactly on a byte boundary: nothing to pad.
            flush_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            acc_q   <= '0;
            fill_q  <= '0;
            rem_q   <= '0;
            flush_q <= 1'b0;
            state_q <= EXP_COUNT;
        end else begin
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            rem_q   <= rem_d;
            flush_q <= flush_d;
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_sink_byte_packer.sv
// Self-checking bench for sink_byte_packer. Two instances (4-bit and 3-bit
// words) share clock and reset. Expected bytes come from a bit-queue model of
// the frame format: append each word MSB-first, and at frame end pad to a
// byte boundary and mark the final byte.
module tb_sink_byte_packer;

    logic       clk = 1'b0;
    logic       arstn, clr;

    logic       sv4, sr4, ov4, or4, ol4;
    logic [3:0] snk4;
    logic [7:0] od4;
    logic       sv3, sr3, ov3, or3, ol3;
    logic [2:0] snk3;
    logic [7:0] od3;

    sink_byte_packer #(.WORD_WIDTH(4), .BYTE_WIDTH(8)) dut4 (
        .clk(clk), .arstn(arstn), .clr(clr),
        .snk_valid(sv4), .snk_ready(sr4), .snk(snk4),
        .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_last(ol4)
    );

    sink_byte_packer #(.WORD_WIDTH(3), .BYTE_WIDTH(8)) dut3 (
        .clk(clk), .arstn(arstn), .clr(clr),
        .snk_valid(sv3), .snk_ready(sr3), .snk(snk3),
        .out_valid(ov3), .out_ready(or3), .out_data(od3), .out_last(ol3)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int exp_d[$];
    bit exp_l[$];

    task automatic check(input string tag, input int obs, input int expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model: frame-level bit packing.
    task automatic build_exp(input int w, input int words[$]);
        int bitq[$];
        int rem;
        bit fin;
        int byt;
        rem = -1;
        foreach (words[i]) begin
            fin = 1'b0;
            for (int b = w - 1; b >= 0; b--) bitq.push_back((words[i] >> b) & 1);
            if (rem < 0) begin
                if (words[i] == 0) fin = 1'b1;
                else rem = words[i];
            end else begin
                rem--;
                if (rem == 0) fin = 1'b1;
            end
            if (fin) begin
                rem = -1;
                while (bitq.size() % 8 != 0) bitq.push_back(0);
            end
            while (bitq.size() >= 8) begin
                byt = 0;
                for (int k = 0; k < 8; k++) byt = (byt << 1) | bitq.pop_front();
                exp_d.push_back(byt);
                exp_l.push_back(fin && (bitq.size() == 0));
            end
        end
    endtask

    // Streams words into the selected instance and scores every output byte.
    // mode 0: out_ready always 1; 1: random valid/ready; 2: hold out_ready
    // low for the first 10 cycles a byte is offered.
    task automatic run_stream(input int w, input int words[$], input int mode);
        int  idx, cyc, hold, wd;
        bit  sv, rdy, sr, ov, ol, stable_chk;
        int  od, prev_od;
        idx = 0; cyc = 0; hold = 0; stable_chk = 1'b0; prev_od = 0;
        build_exp(w, words);
        while ((idx < words.size() || exp_d.size() > 0) && cyc < 3000) begin
            @(negedge clk);
            if (w == 4) begin sr = sr4; ov = ov4; ol = ol4; od = int'(od4); end
            else        begin sr = sr3; ov = ov3; ol = ol3; od = int'(od3); end
            check("ready_vs_valid", int'(sr), int'(!ov));
            if (stable_chk) check("data_stable", od, prev_od);
            sv = (idx < words.size()) && (mode != 1 || $urandom_range(0, 3) != 0);
            wd = (idx < words.size()) ? words[idx] : 0;
            if (mode == 1)               rdy = ($urandom_range(0, 2) != 0);
            else if (mode == 2 && ov && hold < 10) begin rdy = 1'b0; hold++; end
            else                         rdy = 1'b1;
            if (w == 4) begin sv4 = sv; snk4 = 4'(wd); or4 = rdy; end
            else        begin sv3 = sv; snk3 = 3'(wd); or3 = rdy; end
            if (sv && sr) idx++;
            if (ov && rdy) begin
                if (exp_d.size() == 0) begin
                    check("extra_byte", od, -1);
                end else begin
                    check("out_data", od, exp_d.pop_front());
                    check("out_last", int'(ol), int'(exp_l.pop_front()));
                end
            end
            stable_chk = ov && !rdy;
            prev_od    = od;
            cyc++;
        end
        if (cyc >= 3000) begin
            check("stream_timeout", cyc, 0);
            exp_d.delete();
            exp_l.delete();
        end
        // After the last byte nothing further may appear.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (w == 4) begin sv4 = 1'b0; or4 = 1'b1; check("idle_valid4", int'(ov4), 0); end
            else        begin sv3 = 1'b0; or3 = 1'b1; check("idle_valid3", int'(ov3), 0); end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sr4"}, int'(sr4), 1);
        check({tag, "_ov4"}, int'(ov4), 0);
        check({tag, "_od4"}, int'(od4), 0);
        check({tag, "_ol4"}, int'(ol4), 0);
    endtask

    // Loads words 2,5 with out_ready low so a byte is pending.
    task automatic load_partial();
        @(negedge clk); or4 = 1'b0; sv4 = 1'b1; snk4 = 4'd2;
        @(negedge clk); snk4 = 4'd5;
        @(negedge clk); sv4 = 1'b0;
        check("pending_valid", int'(ov4), 1);
        check("pending_data", int'(od4), 'h25);
    endtask

    initial begin
        int q[$];
        int c;
        arstn = 1'b0; clr = 1'b0;
        sv4 = 1'b0; or4 = 1'b0; snk4 = '0;
        sv3 = 1'b0; or3 = 1'b0; snk3 = '0;
        #12;
        check_reset_outputs("reset");
        check("reset_sr3", int'(sr3), 1);
        check("reset_ov3", int'(ov3), 0);
        @(negedge clk); arstn = 1'b1;

        q = {2, 5, 1};       run_stream(4, q, 0);
        q = {0, 1, 3};       run_stream(4, q, 0);
        q = {2, 4, 1};       run_stream(3, q, 0);
        q = {2, 5, 1};       run_stream(4, q, 2);
        q = {3, 7, 6, 0};    run_stream(4, q, 0);

        // Asynchronous reset mid-frame discards the pending byte.
        load_partial();
        #2 arstn = 1'b0;
        #1 check_reset_outputs("arst_mid");
        @(negedge clk); arstn = 1'b1;
        q = {1, 3};          run_stream(4, q, 0);

        // Synchronous clear wins over a simultaneous output handshake.
        load_partial();
        clr = 1'b1; or4 = 1'b1;
        @(negedge clk); clr = 1'b0; or4 = 1'b0;
        check_reset_outputs("clr_mid");
        q = {1, 3};          run_stream(4, q, 0);

        // Randomized frames with random valid gaps and backpressure.
        for (int w = 3; w <= 4; w++) begin
            q.delete();
            for (int f = 0; f < 25; f++) begin
                c = $urandom_range(0, 6);
                q.push_back(c);
                for (int j = 0; j < c; j++) q.push_back($urandom_range(0, (1 << w) - 1));
            end
            run_stream(w, q, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
